// File: rtl/pipeline_defs.sv
// Shared definitions for the data-memory arbiter: FSM encodings, request record and
// counter-width helpers.
package pipeline_defs;

    localparam logic [1:0] ARB_S_IDLE = 2'd0;
    localparam logic [1:0] ARB_S_CORE = 2'd1;
    localparam logic [1:0] ARB_S_DMA  = 2'd2;

    // lat_cnt width for the default MEM_LAT; parameterised users call arb_cnt_w().
    localparam int unsigned ARB_DEF_MEM_LAT = 1;
    localparam int unsigned ARB_LAT_W       = $clog2(ARB_DEF_MEM_LAT + 1);

    typedef enum logic {
        OwnCore = 1'b0,
        OwnDma  = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd;
        logic        wr;
        arb_owner_e  owner;
    } arb_req_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned arb_cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/arb_req_latch.sv
// Holds the arbitration winner's request for the remaining cycles of a multi-cycle read.
module arb_req_latch
    import pipeline_defs::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     load_i,
    input  arb_req_t req_i,
    output arb_req_t req_o
);

    arb_req_t req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q <= '{addr: 32'h0, wdata: 32'h0, rd: 1'b0, wr: 1'b0, owner: OwnCore};
        end else if (load_i) begin
            req_q <= req_i;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the data-RAM port between the core MEM stage and a DMA/debug master.
// Core has priority; a saturating wait counter guarantees the DMA a slot.
module mem_bus_arbiter
    import pipeline_defs::*;
#(
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iCoreAddr,
    input  logic        iCoreRead,
    input  logic        iCoreWrite,
    input  logic [31:0] iCoreWriteData,
    output logic [31:0] oCoreReadData,
    output logic        oCoreStall,
    input  logic        iDmaReq,
    input  logic        iDmaWrite,
    input  logic [31:0] iDmaAddr,
    input  logic [31:0] iDmaWriteData,
    output logic        oDmaGnt,
    output logic        oDmaRdValid,
    output logic [31:0] oDmaRdData,
    output logic [31:0] oMemAddr,
    output logic        oMemRead,
    output logic        oMemWrite,
    output logic [31:0] oMemWriteData,
    input  logic [31:0] iMemReadData
);

    localparam int unsigned      LatW     = arb_cnt_w(MEM_LAT);
    localparam int unsigned      WaitW    = arb_cnt_w(MAX_WAIT);
    localparam logic [LatW-1:0]  LatLast  = LatW'(MEM_LAT - 1);
    localparam logic [WaitW-1:0] WaitMax  = WaitW'(MAX_WAIT);
    localparam bit               SingleRd = (MEM_LAT == 1);

    logic [1:0]       state_q, state_d;
    logic [LatW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;

    logic     core_req, core_rd, dma_pri, win_dma, win_core;
    logic     latch_load, done, done_rd, own_dma;
    arb_req_t arb_req, lat_req;

    logic [31:0] mem_addr, mem_wdata, core_rdata, dma_rdata;
    logic        mem_read, mem_write, core_stall, dma_gnt, dma_rdvalid;

    // Arbitration; read+write from the core collapses to a write.
    always_comb begin
        core_req = iCoreRead | iCoreWrite;
        core_rd  = iCoreRead & ~iCoreWrite;
        dma_pri  = iDmaReq && (wait_cnt_q == WaitMax);
        win_dma  = dma_pri || (iDmaReq && !core_req);
        win_core = core_req && !dma_pri;

        arb_req.owner = win_dma ? OwnDma : OwnCore;
        arb_req.addr  = win_dma ? iDmaAddr : iCoreAddr;
        arb_req.wdata = win_dma ? iDmaWriteData : iCoreWriteData;
        arb_req.rd    = win_dma ? ~iDmaWrite : core_rd;
        arb_req.wr    = win_dma ? iDmaWrite : iCoreWrite;
    end

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        latch_load = 1'b0;
        done       = 1'b0;
        done_rd    = 1'b0;
        own_dma    = 1'b0;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;

        unique case (state_q)
            ARB_S_IDLE: begin
                if (win_dma || win_core) begin
                    mem_addr  = arb_req.addr;
                    mem_wdata = arb_req.wdata;
                    mem_read  = arb_req.rd;
                    mem_write = arb_req.wr;
                    own_dma   = win_dma;
                    done_rd   = arb_req.rd;
                    if (arb_req.wr || SingleRd) begin
                        done = 1'b1;
                    end else begin
                        state_d    = win_dma ? ARB_S_DMA : ARB_S_CORE;
                        lat_cnt_d  = LatW'(1);
                        latch_load = 1'b1;
                    end
                end
            end
            ARB_S_CORE, ARB_S_DMA: begin
                // Only reads are ever latched, so rd stays high and wr low here.
                mem_addr  = lat_req.addr;
                mem_wdata = lat_req.wdata;
                mem_read  = lat_req.rd;
                mem_write = lat_req.wr;
                own_dma   = (lat_req.owner == OwnDma);
                done_rd   = 1'b1;
                if (lat_cnt_q == LatLast) begin
                    done      = 1'b1;
                    state_d   = ARB_S_IDLE;
                    lat_cnt_d = '0;
                end else begin
                    lat_cnt_d = lat_cnt_q + LatW'(1);
                end
            end
            default: begin
                state_d   = ARB_S_IDLE;
                lat_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        core_stall  = core_req && !(done && !own_dma);
        core_rdata  = (done && !own_dma && done_rd) ? iMemReadData : 32'h0;
        dma_gnt     = done && own_dma;
        dma_rdvalid = dma_gnt && done_rd;
        dma_rdata   = dma_rdvalid ? iMemReadData : 32'h0;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!iDmaReq || dma_gnt) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_S_IDLE;
            lat_cnt_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    arb_req_latch u_req_latch (
        .clk    (clk),
        .reset  (reset),
        .load_i (latch_load),
        .req_i  (arb_req),
        .req_o  (lat_req)
    );

    // Reset forces every output quiet, even while requests are still asserted.
    assign oMemAddr      = reset ? 32'h0 : mem_addr;
    assign oMemWriteData = reset ? 32'h0 : mem_wdata;
    assign oMemRead      = reset ? 1'b0 : mem_read;
    assign oMemWrite     = reset ? 1'b0 : mem_write;
    assign oCoreStall    = reset ? 1'b0 : core_stall;
    assign oCoreReadData = reset ? 32'h0 : core_rdata;
    assign oDmaGnt       = reset ? 1'b0 : dma_gnt;
    assign oDmaRdValid   = reset ? 1'b0 : dma_rdvalid;
    assign oDmaRdData    = reset ? 32'h0 : dma_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: three instances (MEM_LAT 1/3/2) each with a RAM model.
module tb_mem_bus_arbiter;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [31:0] core_addr  [NDUT];
    logic        core_rd    [NDUT];
    logic        core_wr    [NDUT];
    logic [31:0] core_wdata [NDUT];
    logic [31:0] core_rdata [NDUT];
    logic        core_stall [NDUT];
    logic        dma_req    [NDUT];
    logic        dma_wr     [NDUT];
    logic [31:0] dma_addr   [NDUT];
    logic [31:0] dma_wdata  [NDUT];
    logic        dma_gnt    [NDUT];
    logic        dma_rdv    [NDUT];
    logic [31:0] dma_rdata  [NDUT];
    logic [31:0] mem_addr   [NDUT];
    logic        mem_read   [NDUT];
    logic        mem_write  [NDUT];
    logic [31:0] mem_wdata  [NDUT];
    logic [31:0] mem_rdata  [NDUT];

    int n_total = 0;
    int n_pass  = 0;

    // {is_read, expected read data}
    logic [32:0] q_core[$];
    logic [32:0] q_dma[$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int unsigned Lat  = (g == 0) ? 1 : (g == 1) ? 3 : 2;
        localparam int unsigned Wait = (g == 0) ? 4 : 8;

        logic [31:0] ram [256];
        int          rd_cnt = 0;

        initial begin
            for (int k = 0; k < 256; k++) ram[k] = 32'h0;
            ram[8'h40] = 32'hDEADBEEF;
            ram[8'h80] = 32'hCAFE0200;
            ram[8'h10] = 32'h11112222;
            ram[8'h11] = 32'h33334444;
        end

        // Read data is only valid on the MEM_LAT-th consecutive read cycle.
        always @(posedge clk) begin
            if (mem_write[g]) ram[mem_addr[g][9:2]] <= mem_wdata[g];
            if (reset) rd_cnt <= 0;
            else if (mem_read[g] && rd_cnt != int'(Lat) - 1) rd_cnt <= rd_cnt + 1;
            else rd_cnt <= 0;
        end

        assign mem_rdata[g] = (mem_read[g] && rd_cnt == int'(Lat) - 1) ?
                              ram[mem_addr[g][9:2]] : 32'hBAD0BAD0;

        mem_bus_arbiter #(
            .MEM_LAT  (Lat),
            .MAX_WAIT (Wait)
        ) u_dut (
            .clk            (clk),
            .reset          (reset),
            .iCoreAddr      (core_addr[g]),
            .iCoreRead      (core_rd[g]),
            .iCoreWrite     (core_wr[g]),
            .iCoreWriteData (core_wdata[g]),
            .oCoreReadData  (core_rdata[g]),
            .oCoreStall     (core_stall[g]),
            .iDmaReq        (dma_req[g]),
            .iDmaWrite      (dma_wr[g]),
            .iDmaAddr       (dma_addr[g]),
            .iDmaWriteData  (dma_wdata[g]),
            .oDmaGnt        (dma_gnt[g]),
            .oDmaRdValid    (dma_rdv[g]),
            .oDmaRdData     (dma_rdata[g]),
            .oMemAddr       (mem_addr[g]),
            .oMemRead       (mem_read[g]),
            .oMemWrite      (mem_write[g]),
            .oMemWriteData  (mem_wdata[g]),
            .iMemReadData   (mem_rdata[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic fail_evt(input string name);
        n_total++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: pops an expectation whenever a DUT completes an access.
    always @(negedge clk) begin
        logic [32:0] e;
        if (!reset) begin
            for (int i = 0; i < NDUT; i++) begin
                if ((core_rd[i] || core_wr[i]) && !core_stall[i]) begin
                    if (q_core.size() == 0) begin
                        fail_evt($sformatf("core_unexpected[%0d]", i));
                    end else begin
                        e = q_core.pop_front();
                        chk($sformatf("core_rdata[%0d]", i), core_rdata[i], e[31:0]);
                    end
                end
                if (dma_gnt[i]) begin
                    if (q_dma.size() == 0) begin
                        fail_evt($sformatf("dma_unexpected[%0d]", i));
                    end else begin
                        e = q_dma.pop_front();
                        chk($sformatf("dma_rdvalid[%0d]", i), 32'(dma_rdv[i]), 32'(e[32]));
                        chk($sformatf("dma_rdata[%0d]", i), dma_rdata[i], e[31:0]);
                        chk($sformatf("stall_on_gnt[%0d]", i), 32'(core_stall[i]),
                            32'(core_rd[i] | core_wr[i]));
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the completion cycle.
    task automatic core_op(input int i, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           output int stalls, output int rd_cycles);
        bit fin = 1'b0;
        q_core.push_back({!wr, wr ? 32'h0 : exp_rd});
        core_addr[i] = a; core_wdata[i] = d; core_rd[i] = !wr; core_wr[i] = wr;
        stalls = 0; rd_cycles = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_read[i] && mem_addr[i] == a) rd_cycles++;
            if (!core_stall[i]) begin
                fin = 1'b1;
                break;
            end
            stalls++;
        end
        if (!fin) begin
            n_total++;
            $display("FAIL core_timeout[%0d]: got stall for %0d cycles, expected completion", i, stalls);
        end
        @(posedge clk); #1;
        core_rd[i] = 1'b0; core_wr[i] = 1'b0; core_addr[i] = 32'h0; core_wdata[i] = 32'h0;
    endtask

    task automatic dma_op(input int i, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, output int waits);
        bit fin = 1'b0;
        q_dma.push_back({!wr, wr ? 32'h0 : exp_rd});
        dma_addr[i] = a; dma_wdata[i] = d; dma_wr[i] = wr; dma_req[i] = 1'b1;
        waits = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dma_gnt[i]) begin
                fin = 1'b1;
                break;
            end
            waits++;
        end
        if (!fin) begin
            n_total++;
            $display("FAIL dma_timeout[%0d]: got no grant in %0d cycles, expected grant", i, waits);
        end
        @(posedge clk); #1;
        dma_req[i] = 1'b0; dma_wr[i] = 1'b0; dma_addr[i] = 32'h0; dma_wdata[i] = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, rc, w1, w2, n40, nrd, ngnt;
        int cst [11];
        int exp_cst [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};

        // Requests held during reset must not leak through to any output.
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            core_addr[i] = 32'h100; core_rd[i] = 1'b1; core_wr[i] = 1'b0;
            core_wdata[i] = 32'h0;
            dma_req[i] = 1'b1; dma_wr[i] = 1'b1; dma_addr[i] = 32'h104;
            dma_wdata[i] = 32'h77;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            chk($sformatf("reset_strobes[%0d]", i),
                {27'h0, core_stall[i], mem_read[i], mem_write[i], dma_gnt[i], dma_rdv[i]},
                32'h0);
            chk($sformatf("reset_data[%0d]", i),
                mem_addr[i] | mem_wdata[i] | core_rdata[i] | dma_rdata[i], 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < NDUT; i++) begin
            core_addr[i] = 32'h0; core_rd[i] = 1'b0; dma_req[i] = 1'b0;
            dma_wr[i] = 1'b0; dma_addr[i] = 32'h0; dma_wdata[i] = 32'h0;
        end

        // MEM_LAT=1 core load completes in the arbitration cycle.
        core_op(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, st, rc);
        chk("t1_stall", st, 0);

        // MEM_LAT=3 core load: 2 stall cycles, 3 read cycles, then idle.
        core_op(1, 1'b0, 32'h200, 32'h0, 32'hCAFE0200, st, rc);
        chk("t2_stall", st, 2);
        chk("t2_read_cycles", rc, 3);
        @(negedge clk);
        chk("t2_idle_after", 32'(mem_read[1]), 32'h0);
        @(posedge clk); #1;

        // Same-cycle core and DMA writes: core first, DMA the next cycle.
        fork
            core_op(0, 1'b1, 32'h300, 32'h55, 32'h0, st, rc);
            dma_op(0, 1'b1, 32'h300, 32'h55, 32'h0, w1);
        join
        chk("t3_core_stall", st, 0);
        chk("t3_dma_wait", w1, 1);
        chk("t3_ram", g_dut[0].ram[8'hC0], 32'h55);
        repeat (2) @(posedge clk); #1;

        // MAX_WAIT=4 starvation guard under a continuous core stream.
        fork
            begin
                dma_op(0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, w1);
                dma_op(0, 1'b1, 32'h1F0, 32'hA5A5, 32'h0, w2);
            end
            for (int k = 0; k < 11; k++) begin
                core_op(0, 1'b1, 32'h180 + 32'(4 * k), 32'(k), 32'h0, cst[k], rc);
            end
        join
        chk("t4_dma1_wait", w1, 4);
        chk("t4_dma2_wait", w2, 4);
        for (int k = 0; k < 11; k++) chk($sformatf("t4_core_stall_%0d", k), cst[k], exp_cst[k]);
        chk("t4_ram_dma_wr", g_dut[0].ram[8'h7C], 32'hA5A5);
        repeat (2) @(posedge clk); #1;

        // Reset in the 2nd cycle of a MEM_LAT=3 DMA read aborts it silently.
        dma_addr[1] = 32'h200; dma_wr[1] = 1'b0; dma_req[1] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; dma_req[1] = 1'b0;
        @(negedge clk);
        chk("t5_gnt_in_reset", 32'(dma_gnt[1]), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_strobes_after", {29'h0, mem_read[1], mem_write[1], dma_gnt[1]}, 32'h0);
        ngnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (dma_gnt[1]) ngnt++;
        end
        chk("t5_no_gnt", ngnt, 0);
        @(posedge clk); #1;

        // MEM_LAT=2 DMA read then core read back-to-back, no overlapping windows.
        fork
            dma_op(2, 1'b0, 32'h040, 32'h0, 32'h11112222, w1);
            begin
                @(posedge clk); #1;
                core_op(2, 1'b0, 32'h044, 32'h0, 32'h33334444, st, rc);
            end
            begin
                n40 = 0; nrd = 0;
                repeat (5) begin
                    @(negedge clk);
                    if (mem_read[2]) nrd++;
                    if (mem_read[2] && mem_addr[2] == 32'h040) n40++;
                end
            end
        join
        chk("t6_dma_wait", w1, 1);
        chk("t6_core_stall", st, 2);
        chk("t6_core_rd_cycles", rc, 2);
        chk("t6_dma_rd_cycles", n40, 2);
        chk("t6_total_rd_cycles", nrd, 4);

        repeat (2) @(posedge clk);
        chk("leftover_core", q_core.size(), 0);
        chk("leftover_dma", q_dma.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
